// File: rtl/cic_pkg.sv
// Shared constants and width helper for the multi-stage CIC decimator.
package cic_pkg;

  localparam int MAX_ORDER = 6;

  // Register growth is ex bits per integrator/comb pair on top of the input width.
  function automatic int cic_width(input int dw, input int order, input int ex);
    return dw + order * ex;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One differentiator stage of the CIC comb chain: out = in - previous in, on valid only.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int w = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [w-1:0] in,
  input  logic         in_valid,
  output logic [w-1:0] out,
  output logic         out_valid
);

  logic [w-1:0] h_q, h_d;
  logic [w-1:0] c_q, c_d;
  logic         v_q, v_d;

  always_comb begin
    h_d = h_q;
    c_d = c_q;
    if (in_valid) begin
      c_d = in - h_q;
      h_d = in;
    end else begin
      c_d = c_q;
      h_d = h_q;
    end
    v_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      c_q <= '0;
      v_q <= 1'b0;
    end else begin
      h_q <= h_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign out       = c_q;
  assign out_valid = v_q;

endmodule

// File: rtl/cic_multi_dec.sv
// Nth-order CIC decimator with runtime ratio or external block marker, and a
// comb chain that is pipelined so a new block may end on every input gate.
module cic_multi_dec
  import cic_pkg::*;
#(
  parameter int dw        = 16,
  parameter int ex        = 10,
  parameter int order     = 3,
  parameter int signed_io = 0,
  parameter int ext_roll  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [dw-1:0] data_in,
  input  logic          data_in_gate,
  input  logic          roll,
  input  logic [ex-1:0] rate,
  output logic [dw-1:0] data_out,
  output logic          data_out_gate
);

  localparam int W = cic_width(dw, order, ex);

  logic [W-1:0]  x_s;
  logic [W-1:0]  int_chain_s [order+1];
  logic [W-1:0]  comb_s      [order+1];
  logic          valid_s     [order+1];
  logic          roll_s;
  logic [ex-1:0] div_q, div_d;
  logic          v0_q, v0_d;
  logic [dw-1:0] data_out_q, data_out_d;
  logic          data_out_gate_q, data_out_gate_d;

  if (signed_io != 0) begin : g_sext
    assign x_s = {{(W-dw){data_in[dw-1]}}, data_in};
  end else begin : g_zext
    assign x_s = {{(W-dw){1'b0}}, data_in};
  end

  assign int_chain_s[0] = x_s;

  // Each integrator adds the pre-edge value of its predecessor, so the cascade
  // carries order-1 cycles of extra delay that the comb output absorbs.
  for (genvar k = 1; k <= order; k++) begin : g_int
    logic [W-1:0] acc_q, acc_d;

    always_comb begin
      if (data_in_gate) begin
        acc_d = acc_q + int_chain_s[k-1];
      end else begin
        acc_d = acc_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end

    assign int_chain_s[k] = acc_q;
  end

  // Block-end decision; comparing with >= lets a lowered rate end the block at once.
  always_comb begin
    roll_s = 1'b0;
    div_d  = div_q;
    if (data_in_gate) begin
      if (ext_roll != 0) begin
        roll_s = roll;
      end else begin
        roll_s = (div_q >= rate);
      end
      if (roll_s) begin
        div_d = '0;
      end else begin
        div_d = div_q + ex'(1);
      end
    end else begin
      roll_s = 1'b0;
      div_d  = div_q;
    end
    v0_d = roll_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      v0_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      v0_q  <= v0_d;
    end
  end

  assign comb_s[0]  = int_chain_s[order];
  assign valid_s[0] = v0_q;

  for (genvar k = 1; k <= order; k++) begin : g_comb
    cic_comb_stage #(.w(W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (comb_s[k-1]),
      .in_valid (valid_s[k-1]),
      .out      (comb_s[k]),
      .out_valid(valid_s[k])
    );
  end

  always_comb begin
    if (valid_s[order]) begin
      data_out_d = comb_s[order][W-1 -: dw];
    end else begin
      data_out_d = data_out_q;
    end
    data_out_gate_d = valid_s[order];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q      <= '0;
      data_out_gate_q <= 1'b0;
    end else begin
      data_out_q      <= data_out_d;
      data_out_gate_q <= data_out_gate_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_out_gate = data_out_gate_q;

endmodule

// File: doc/cic_multi_dec.md
Name: cic_multi_dec

Overview:
- Parametrised Nth-order CIC decimator.
- Generalises the first-order simple CIC in four ways:
  - selectable order
  - runtime decimation ratio
  - signed or unsigned I/O
  - pipelined comb chain that accepts a roll on every input gate
- Sits between ADC/DDS sample streams and slow-rate readout or feedback logic.

Parameters:
- dw, 16: input/output data width.
- ex, 10: log2 of the maximum decimation ratio; width of the rate and counter fields.
- order, 3: number of integrator and comb stages, 1..6.
- signed_io, 0: 0 = unsigned zero-extend; 1 = two's-complement sign-extend.
- ext_roll, 0: 1 = roll port selects block ends; 0 = internal counter against rate.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  dw  input sample.
- data_in_gate  in  1  data_in valid this cycle.
- roll  in  1  block-end marker, sampled only when data_in_gate=1; ignored unless ext_roll=1.
- rate  in  ex  decimation ratio minus 1, giving ratio rate+1 (1..2^ex); ignored when ext_roll=1.
- data_out  out  dw  decimated sample.
- data_out_gate  out  1  one-cycle strobe; data_out valid.

Behaviour:
- Reset:
  - rst_n low clears all integrators, comb delay registers, comb outputs, div counter, valid pipeline, data_out and data_out_gate to 0.
  - Effect is immediate (asynchronous). No output strobe until a full block completes after release.
- Internal width: W = dw + order*ex.
- Input extension to W: zero-extended when signed_io=0, sign-extended when signed_io=1.
- Integrators:
  - Run only on edges where data_in_gate=1.
  - i1 <= i1 + x; ik <= ik + i(k-1), using the pre-edge value of i(k-1).
  - All arithmetic is modulo 2^W; wrap-around is intended and never flagged.
- Roll decision (evaluated on the same gated edge T0):
  - ext_roll=0: roll when div >= rate, and div <= 0; otherwise div <= div+1. A rate lowered below div forces a roll at the next gate.
  - ext_roll=1: roll = roll port value at T0.
- Comb chain:
  - A valid bit v0 is registered at T0 (set iff roll).
  - At edge T0+1, if v0: c1 <= iN - h1; h1 <= iN.
  - At edge T0+k (k=2..order), if v(k-1): ck <= c(k-1) - hk; hk <= c(k-1).
  - The valid bit shifts one stage per clk, independent of data_in_gate, so gaps are not required.
  - Rolls on consecutive clk cycles (gate every cycle, rate=0) must be handled with no loss.
- Output:
  - data_out = c_order[W-1 : W-dw], registered.
  - data_out_gate pulses for exactly one cycle following edge T0+order+1.
  - Latency from the completing gated edge to the strobe: order+1 clk.
  - data_out holds its value between strobes.
- Gain is (rate+1)^order, so full scale holds only at rate = 2^ex-1. Smaller ratios scale the output down; compensating for this is the consumer's job.
- Transients: the first order-1 outputs after reset or after a rate change are not settled. No masking is applied.
- data_in_gate low: integrators and div hold, and the comb pipeline continues draining.

Decomposition:
- Shared package cic_pkg: localparam function cic_width(dw,order,ex); constant MAX_ORDER=6.
- One natural sub-module: cic_comb_stage, with parameter w; ports clk, rst_n, in, in_valid, out, out_valid. The top instantiates order copies via generate.
- Integrators are kept inline in a generate loop.

Test Plan:
- order=1, ex=4, rate=15, unsigned, constant 1000 gated every cycle -> every output 1000; strobe period 16 clk; strobe 2 clk after the 16th gate.
- order=3, ex=4, rate=15, unsigned, constant 100 -> outputs from the 3rd strobe onward equal 100 (gain 4096, W=28).
- order=3, ex=4, signed_io=1, constant -50 -> settled data_out = 16'hFFCE.
- order=3, ex=4, rate=7, constant 100 -> settled output 12 (100*512>>12); strobe period 8 gates. Then change rate from 7 to 2 while div=5 -> roll at the next gate, then period 3.
- ext_roll=1, rate=0 path, roll high on every gate with gates every cycle -> data_out_gate high on every cycle after the (order+1)-cycle latency; no dropped strobes. Gate every 3rd cycle with roll every 4th gate -> strobe every 12 clk.
- Assert rst_n low for 1 cycle mid-block -> data_out and data_out_gate go to 0 immediately. The first strobe after release comes exactly rate+1 gates plus order+1 clk later.
